// File: rtl/hamming_encoder_stream.sv
// hamming_encoder_stream: SECDED Hamming(12,8)+word-parity encoder with skid-buffered stream output
module hamming_encoder_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [12:0]      in_inject,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [12:0]      out_code,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] inject_count
);
    logic [11:0] cw;
    logic [12:0] enc;
    logic        p1, p2, p4, p8;
    logic        inj, accept, load, fire;
    logic        out_inj, skid_full, skid_inj;
    logic [12:0] skid_code;

    assign p1 = in_data[0] ^ in_data[1] ^ in_data[3] ^ in_data[4] ^ in_data[6];
    assign p2 = in_data[0] ^ in_data[2] ^ in_data[3] ^ in_data[5] ^ in_data[6];
    assign p4 = in_data[1] ^ in_data[2] ^ in_data[3] ^ in_data[7];
    assign p8 = ^in_data[7:4];
    assign cw = {in_data[7:4], p8, in_data[3:1], p4, in_data[0], p2, p1};
    assign enc = {^cw, cw} ^ in_inject;
    assign inj = |in_inject;

    assign in_ready = ~skid_full;
    assign accept = in_valid & ~skid_full;
    assign fire = out_valid & out_ready;
    assign load = ~out_valid | out_ready;

    // output register refills from skid first, then input; skid catches a word accepted during a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_code  <= 13'd0;
            out_inj   <= 1'b0;
            skid_full <= 1'b0;
            skid_code <= 13'd0;
            skid_inj  <= 1'b0;
        end else if (load) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                out_code  <= skid_code;
                out_inj   <= skid_inj;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_code  <= enc;
                out_inj   <= inj;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
            skid_code <= enc;
            skid_inj  <= inj;
        end
    end

    // saturating delivery counters; clear overrides a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count   <= '0;
            inject_count <= '0;
        end else if (clear_counts) begin
            word_count   <= '0;
            inject_count <= '0;
        end else if (fire) begin
            if (word_count != '1)
                word_count <= word_count + CNT_W'(1);
            if (out_inj && inject_count != '1)
                inject_count <= inject_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hamming_encoder_stream.sv
// tb_hamming_encoder_stream: directed checks of encoding, handshake, skid, counters and reset
module tb_hamming_encoder_stream;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, clear_counts;
    logic [7:0]  in_data;
    logic [12:0] in_inject;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [12:0] out_code, out_code2;
    logic [15:0] word_count, inject_count;
    logic [1:0]  word_count2, inject_count2;
    int          n_cmp = 0;
    int          n_err = 0;

    hamming_encoder_stream dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inject(in_inject), .out_valid(out_valid),
        .out_ready(out_ready), .out_code(out_code), .clear_counts(clear_counts),
        .word_count(word_count), .inject_count(inject_count)
    );

    hamming_encoder_stream #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_inject(in_inject), .out_valid(out_valid2),
        .out_ready(out_ready), .out_code(out_code2), .clear_counts(clear_counts),
        .word_count(word_count2), .inject_count(inject_count2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_counts = 1'b0;
        in_data = 8'h00; in_inject = 13'h0000;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_code", 32'(out_code), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_ic", 32'(inject_count), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        in_valid = 1'b1; in_data = 8'h0F; out_ready = 1'b1;
        tick();
        chk("w0f_valid", 32'(out_valid), 32'd1);
        chk("w0f_code", 32'(out_code), 32'h107F);
        chk("w0f_wc_pre", 32'(word_count), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("w0f_wc", 32'(word_count), 32'd1);
        chk("w0f_drain", 32'(out_valid), 32'd0);

        in_valid = 1'b1; in_data = 8'h00;
        tick();
        chk("b2b_00", 32'(out_code), 32'h0000);
        chk("b2b_00_v", 32'(out_valid), 32'd1);
        in_data = 8'hFF;
        tick();
        chk("b2b_ff", 32'(out_code), 32'h0F77);
        chk("b2b_ff_v", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("b2b_wc", 32'(word_count), 32'd3);
        chk("b2b_drain", 32'(out_valid), 32'd0);

        in_valid = 1'b1; in_data = 8'h0F; in_inject = 13'h0040;
        tick();
        chk("inj_single", 32'(out_code), 32'h103F);
        in_inject = 13'h1000;
        tick();
        chk("inj_wp", 32'(out_code), 32'h007F);
        chk("inj_ic1", 32'(inject_count), 32'd1);
        in_inject = 13'h00C0;
        tick();
        chk("inj_double", 32'(out_code), 32'h10BF);
        in_valid = 1'b0; in_inject = 13'h0000;
        tick();
        chk("inj_ic", 32'(inject_count), 32'd3);
        chk("inj_wc", 32'(word_count), 32'd6);
        chk("sat2_wc_early", 32'(word_count2), 32'd3);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        tick();
        chk("stall_w1", 32'(out_code), 32'h0F77);
        chk("stall_rdy1", 32'(in_ready), 32'd1);
        in_data = 8'h0F;
        tick();
        chk("stall_hold", 32'(out_code), 32'h0F77);
        chk("stall_rdy0", 32'(in_ready), 32'd0);
        in_data = 8'h00;
        tick();
        chk("stall_hold2", 32'(out_code), 32'h0F77);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_rdy0b", 32'(in_ready), 32'd0);
        chk("stall_wc", 32'(word_count), 32'd6);
        out_ready = 1'b1;
        tick();
        chk("rel_w2", 32'(out_code), 32'h107F);
        chk("rel_rdy", 32'(in_ready), 32'd1);
        chk("rel_wc", 32'(word_count), 32'd7);
        tick();
        chk("rel_w3", 32'(out_code), 32'h0000);
        chk("rel_w3_v", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("rel_wc3", 32'(word_count), 32'd9);
        chk("rel_empty", 32'(out_valid), 32'd0);
        tick();
        chk("idle_wc", 32'(word_count), 32'd9);

        in_valid = 1'b1; in_data = 8'h0F;
        tick();
        in_valid = 1'b0; clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        chk("clr_wc", 32'(word_count), 32'd0);
        chk("clr_ic", 32'(inject_count), 32'd0);
        chk("clr_wc2", 32'(word_count2), 32'd0);

        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(i * 37);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("sat_wc16", 32'(word_count), 32'd5);
        chk("sat_wc2", 32'(word_count2), 32'd3);
        chk("sat_ic2_clean", 32'(inject_count2), 32'd0);
        in_valid = 1'b1; in_inject = 13'h0001;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0; in_inject = 13'h0000;
        tick();
        chk("sat_ic16", 32'(inject_count), 32'd4);
        chk("sat_ic2", 32'(inject_count2), 32'd3);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0F;
        tick(); tick();
        chk("pre_rst_rdy", 32'(in_ready), 32'd0);
        chk("pre_rst_v", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_code", 32'(out_code), 32'h0);
        chk("arst_wc", 32'(word_count), 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        chk("post_rst_v", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
